// File: rtl/or1k_wb_burst_ram_pkg.sv
// Shared Wishbone B3 definitions for the or1k_pu bus models: cycle and burst
// type encodings plus the RAM slave state enumeration.
package or1k_wb_pkg;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;

   localparam logic [1:0] BTE_LINEAR  = 2'b00;
   localparam logic [1:0] BTE_WRAP4   = 2'b01;
   localparam logic [1:0] BTE_WRAP8   = 2'b10;
   localparam logic [1:0] BTE_WRAP16  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_BURST = 2'd2
   } state_e;

   // Only an incrementing cycle type keeps a burst open after its ack.
   function automatic logic is_incr_cti(input logic [2:0] cti);
      return (cti == CTI_INCR);
   endfunction

endpackage

// File: rtl/or1k_wb_burst_ram_if.sv
// Wishbone B3 slave-side bundle. Signal names keep the slave's _i/_o view so
// they read the same inside the RAM and on the fabric.
interface or1k_wb_burst_ram_if #(
   parameter int DW = 32,
   parameter int AW = 32
);
   logic [AW-1:0]   wb_adr_i;
   logic [DW-1:0]   wb_dat_i;
   logic [DW/8-1:0] wb_sel_i;
   logic            wb_we_i;
   logic            wb_cyc_i;
   logic            wb_stb_i;
   logic [2:0]      wb_cti_i;
   logic [1:0]      wb_bte_i;
   logic [DW-1:0]   wb_dat_o;
   logic            wb_ack_o;
   logic            wb_err_o;

   modport master (
      output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
             wb_cti_i, wb_bte_i,
      input  wb_dat_o, wb_ack_o, wb_err_o
   );

   modport slave (
      input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
             wb_cti_i, wb_bte_i,
      output wb_dat_o, wb_ack_o, wb_err_o
   );
endinterface

// File: rtl/or1k_wb_burst_addr.sv
// Combinational Wishbone burst next-address generator working in word units.
// Linear bursts add one word; wrap-N bursts keep the upper bits and roll the
// low log2(N) bits modulo N.
module or1k_wb_burst_addr
   import or1k_wb_pkg::*;
#(
   parameter int WAW = 30
) (
   input  logic [WAW-1:0] adr_i,
   input  logic [1:0]     bte_i,
   output logic [WAW-1:0] next_o
);

   logic [WAW-1:0] mask_s;
   logic [WAW-1:0] incr_s;

   assign incr_s = adr_i + WAW'(1'b1);

   // Select the set of address bits that are allowed to change.
   always_comb begin
      mask_s = {WAW{1'b1}};
      case (bte_i)
         BTE_LINEAR: mask_s = {WAW{1'b1}};
         BTE_WRAP4:  mask_s = WAW'(5'd3);
         BTE_WRAP8:  mask_s = WAW'(5'd7);
         BTE_WRAP16: mask_s = WAW'(5'd15);
         default:    mask_s = {WAW{1'b1}};
      endcase
   end

   assign next_o = (adr_i & ~mask_s) | (incr_s & mask_s);

endmodule

// File: rtl/or1k_wb_burst_ram.sv
// Wishbone B3 slave RAM with configurable wait states, registered-feedback
// bursts, byte-lane writes and bus errors for addresses beyond the array.
module or1k_wb_burst_ram
   import or1k_wb_pkg::*;
#(
   parameter int          DW          = 32,
   parameter int          AW          = 32,
   parameter int unsigned MEM_SIZE    = 32'h0000_8000,
   parameter int          WAIT_STATES = 0,
   parameter bit          INIT_ZERO   = 1'b1
) (
   input  logic               wb_clk_i,
   input  logic               wb_rst_i,
   or1k_wb_burst_ram_if.slave wb
);

   localparam int          BYTES   = DW / 8;
   localparam int          ABITS   = $clog2(BYTES);
   localparam int          WAW     = AW - ABITS;
   localparam int unsigned WORDS   = MEM_SIZE / BYTES;
   localparam int          MAW     = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [3:0]  WS_LOAD = 4'(WAIT_STATES - 1);

   // Contents are only defined at time zero when zero-fill is requested.
   logic [DW-1:0] mem_q [WORDS] = '{default: (INIT_ZERO ? {DW{1'b0}} : {DW{1'bx}})};

   state_e         state_q, state_d;
   logic [3:0]     wait_cnt_q, wait_cnt_d;
   logic [WAW-1:0] burst_adr_q, burst_adr_d;
   logic           ack_q, ack_d;
   logic           err_q, err_d;
   logic [DW-1:0]  dat_q, dat_d;

   logic           req_s, hit_s, start_s, term_s, oor_s, mem_we_s;
   logic [WAW-1:0] adr_word_s, access_adr_s, next_adr_s;
   logic [MAW-1:0] mem_idx_s;

   if (ABITS > 0) begin : g_lsb
      logic unused_lsb_s;
      assign unused_lsb_s = ^wb.wb_adr_i[ABITS-1:0];
   end

   assign adr_word_s   = wb.wb_adr_i[AW-1:ABITS];
   assign req_s        = wb.wb_cyc_i & wb.wb_stb_i;
   // A burst beat is only honoured without wait states at the predicted address.
   assign hit_s        = (state_q == ST_BURST) && (adr_word_s == burst_adr_q);
   assign access_adr_s = hit_s ? burst_adr_q : adr_word_s;
   assign oor_s        = 64'(access_adr_s) >= 64'(WORDS);
   assign mem_idx_s    = access_adr_s[MAW-1:0];
   assign mem_we_s     = ack_d & wb.wb_we_i & ~wb_rst_i;

   or1k_wb_burst_addr #(.WAW(WAW)) u_next_adr (
      .adr_i  (access_adr_s),
      .bte_i  (wb.wb_bte_i),
      .next_o (next_adr_s)
   );

   // Next state, wait counting, burst prediction and termination decode.
   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      burst_adr_d = burst_adr_q;
      ack_d       = 1'b0;
      err_d       = 1'b0;
      dat_d       = dat_q;
      start_s     = 1'b0;
      term_s      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // The cycle carrying the previous termination is never a new request.
            if (req_s && !(ack_q || err_q)) begin
               start_s = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (!wb.wb_cyc_i) begin
               state_d = ST_IDLE;
            end else if (wait_cnt_q != 4'd0) begin
               wait_cnt_d = wait_cnt_q - 4'd1;
            end else if (wb.wb_stb_i) begin
               term_s = 1'b1;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_BURST: begin
            if (!wb.wb_cyc_i) begin
               state_d = ST_IDLE;
            end else if (!wb.wb_stb_i) begin
               state_d = ST_BURST;
            end else if (hit_s) begin
               term_s = 1'b1;
            end else begin
               start_s = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (start_s) begin
         if (WAIT_STATES > 0) begin
            state_d    = ST_WAIT;
            wait_cnt_d = WS_LOAD;
         end else begin
            term_s = 1'b1;
         end
      end else begin
         wait_cnt_d = wait_cnt_d;
      end

      if (term_s) begin
         if (oor_s) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
         end else begin
            ack_d = 1'b1;
            if (!wb.wb_we_i) begin
               dat_d = mem_q[mem_idx_s];
            end else begin
               dat_d = dat_q;
            end
            if (is_incr_cti(wb.wb_cti_i)) begin
               state_d     = ST_BURST;
               burst_adr_d = next_adr_s;
            end else begin
               state_d = ST_IDLE;
            end
         end
      end else begin
         burst_adr_d = burst_adr_d;
      end
   end

   // Control and response registers; reset aborts any cycle in flight.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q     <= ST_IDLE;
         wait_cnt_q  <= 4'd0;
         burst_adr_q <= '0;
         ack_q       <= 1'b0;
         err_q       <= 1'b0;
         dat_q       <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         burst_adr_q <= burst_adr_d;
         ack_q       <= ack_d;
         err_q       <= err_d;
         dat_q       <= dat_d;
      end
   end

   // Byte-lane writes land on the acking edge only.
   always_ff @(posedge wb_clk_i) begin
      for (int b = 0; b < BYTES; b++) begin
         if (mem_we_s && wb.wb_sel_i[b]) begin
            mem_q[mem_idx_s][8*b +: 8] <= wb.wb_dat_i[8*b +: 8];
         end
      end
   end

   assign wb.wb_ack_o = ack_q;
   assign wb.wb_err_o = err_q;
   assign wb.wb_dat_o = dat_q;

endmodule

// File: doc/or1k_wb_burst_ram.md
Name: or1k_wb_burst_ram

Overview:
Parametrised Wishbone B3 slave RAM, the next-generation memory model behind the or1k_pu instruction and data buses.
- Generalised in data width, depth and wait states.
- Adds B3 registered-feedback bursts (incrementing and linear-wrap 4/8/16), per-byte write enables, and out-of-range bus errors.
- Sits in the processing-unit bench/SoC on the shared Wishbone fabric, clocked by the system Wishbone clock.

Parameters:
- DW, 32, data width in bits; multiple of 8, minimum 8.
- AW, 32, byte-address width.
- MEM_SIZE, 32'h0000_8000, memory size in bytes; power of two, multiple of DW/8.
- WAIT_STATES, 0, idle cycles inserted before the first ack of each cycle (0..15).
- INIT_ZERO, 1, 1 = array cleared at time zero.

Ports:
- wb_clk_i  in  1  Wishbone clock.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- wb_adr_i  in  AW  byte address; low log2(DW/8) bits ignored.
- wb_dat_i  in  DW  write data.
- wb_sel_i  in  DW/8  byte lane enables.
- wb_we_i  in  1  1 = write.
- wb_cyc_i  in  1  bus cycle valid.
- wb_stb_i  in  1  strobe.
- wb_cti_i  in  3  cycle type: 000 classic, 010 incr burst, 111 end-of-burst.
- wb_bte_i  in  2  burst type: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16.
- wb_dat_o  out  DW  read data.
- wb_ack_o  out  1  normal termination.
- wb_err_o  out  1  error termination.

Behaviour:
- Reset: wb_ack_o=0, wb_err_o=0, wb_dat_o=0, FSM=IDLE, burst address counter=0, wait counter=0. Memory contents are not touched by reset. Reset asserted mid-burst aborts the burst at once; the next cycle starts in IDLE.
- FSM states: IDLE, WAIT, BURST.
- IDLE -> WAIT when cyc&stb and WAIT_STATES>0. Otherwise IDLE -> first ack on the next edge.
- WAIT counts WAIT_STATES edges, then issues the first ack.
- After any ack with cti=010, the FSM enters BURST.
- A beat with cti=000 or 111 returns to IDLE after its ack.
- Terminations are registered; each ack/err is a single-cycle pulse.
- Classic cycle latency: ack asserted on edge WAIT_STATES+1 after cyc&stb is first sampled. ack is deasserted the following cycle, so classic back-to-back cycles need at least one idle cycle between them.
- Burst: after the first ack, subsequent beats are acked on consecutive cycles while cyc&stb stay high (1 beat/cycle).
  - Next beat address: linear adds DW/8.
  - Wrap-N keeps the upper address bits and increments the low log2(N*DW/8) bits modulo N beats.
  - Address arithmetic is done in word units, AW-log2(DW/8) bits wide; linear wrap past the top of AW silently wraps.
- Master stalls (stb low while cyc high, in BURST): no ack; the counter holds; the burst resumes on stb without re-inserting wait states.
- cyc low in any state: immediate return to IDLE; no ack; no pending write is committed.
- Address/cti mismatch: in BURST, if wb_adr_i differs from the predicted address, the beat is treated as a new classic access (wait states reapplied).
- Writes: each byte lane with sel=1 is written on the acking edge. sel=0 lanes are preserved. sel=0 on all lanes still acks.
- Reads: wb_dat_o is valid in the same cycle as ack. It is read from the predicted address so bursts need no bubble. Outside ack, wb_dat_o holds its last value.
- Out of range (word address*DW/8 >= MEM_SIZE): wb_err_o is pulsed instead of ack at the same latency. Writes are suppressed and wb_dat_o is unchanged. An err inside a burst ends the burst (IDLE).
- Simultaneous cti=111 and stall: the end-of-burst beat is only consumed on its ack.
- ack and err are never high together.

Decomposition:
- Package or1k_wb_pkg: CTI_CLASSIC/CTI_INCR/CTI_EOB, BTE_LINEAR/BTE_WRAP4/BTE_WRAP8/BTE_WRAP16 constants, and the FSM state enum.
- Sub-module or1k_wb_burst_addr: combinational next-address generator (inputs: word address, bte, width param). It is shared with future burst masters.

Test Plan:
- Classic read, WAIT_STATES=2, mem[0x10]=32'hDEADBEEF, read adr 0x40 -> ack on 3rd edge after stb, dat_o=DEADBEEF, ack high exactly 1 cycle.
- Byte write: write adr 0x40, dat 32'h11223344, sel=4'b0101, then read -> DEAD33 44 pattern 32'hDEAD_BE44 becomes 32'hDE22BE44 per lanes 0,2 (expected 32'hDE22BE44).
- Wrap4 burst read from adr 0x18 (words 6,7,4,5), mem[i]=i -> acks on 4 consecutive cycles, dat_o = 6,7,4,5; last beat cti=111, FSM back to IDLE.
- Linear burst write 8 beats from 0x100 with a 2-cycle stb stall after beat 3 -> exactly 8 acks, no ack during stall, readback words 0x40..0x47 match.
- Out-of-range: MEM_SIZE=0x8000, write adr 0x8000 -> err pulse instead of ack, mem[0] unchanged; next in-range read acks normally.
- Reset mid-burst: assert wb_rst_i during beat 2 of an incr burst -> ack/err/dat_o=0 asynchronously; after release, a classic read acks with normal latency.
